addsub_rr_arbiter: RTL

- Shares one 12-bit add/subtract datapath among NUM_REQ requesters, e.g. PE accumulate/offset units in the TPU array.
- Arbitrates round-robin and issues at most one operation per cycle.
- Holds each result in a one-deep output register until the consumer accepts it.
- The datapath computes subtraction as a + (~b + 1) modulo 2^WIDTH.

---
 rtl/addsub_rr_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter: round-robin arbiter in front of one shared WIDTH-bit
// add/subtract datapath. The granted operation is computed in the issue cycle
// and held in a one-deep result register until the consumer accepts it.
module addsub_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 12,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ-1:0]       req_op,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDW-1:0]           rsp_id,
   output logic [WIDTH-1:0]         rsp_result,
   output logic                     rsp_flag,
   output logic                     busy
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t                        state_q, state_d;
   logic [IDW-1:0]                ptr_q;
   logic [IDW-1:0]                gnt_id;
   logic                          gnt_any;
   logic                          can_issue;
   logic                          issue;
   logic [NUM_REQ-1:0][WIDTH-1:0] op_a, op_b;
   logic [WIDTH-1:0]              a_sel, b_sel;
   logic                          op_sel;
   logic [WIDTH:0]                sum;

   // Unpack the flattened operand buses into per-requester lanes
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      assign op_a[i] = req_a[i*WIDTH +: WIDTH];
      assign op_b[i] = req_b[i*WIDTH +: WIDTH];
   end

   // Rotating priority search: first valid requester starting at ptr
   always_comb begin : p_grant
      int idx;
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!gnt_any && req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = IDW'(idx);
         end
      end
   end

   // The register can take a new result when empty or when being drained now.
   // rst_n gates issue so nothing is accepted while reset is held.
   assign can_issue = (state_q == EMPTY) || (rsp_valid && rsp_ready);
   assign issue     = rst_n && gnt_any && can_issue;

   // One-hot accept to the granted requester; independent of op and operands
   always_comb begin
      req_ready = '0;
      if (issue) req_ready[gnt_id] = 1'b1;
   end

   // Shared datapath: subtract is a + ~b + 1, so carry-out inverted is borrow
   assign a_sel  = op_a[gnt_id];
   assign b_sel  = op_b[gnt_id];
   assign op_sel = req_op[gnt_id];
   assign sum    = {1'b0, a_sel} + {1'b0, (op_sel ? ~b_sel : b_sel)}
                 + {{WIDTH{1'b0}}, op_sel};

   // Next state: issue fills (or refills) the register, a lone drain empties it
   always_comb begin
      state_d = state_q;
      if (issue)
         state_d = FULL;
      else if (state_q == FULL && rsp_ready)
         state_d = EMPTY;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Result register and round-robin pointer; both move only on an issue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_result <= '0;
         rsp_flag   <= 1'b0;
         rsp_id     <= '0;
         ptr_q      <= '0;
      end else if (issue) begin
         rsp_result <= sum[WIDTH-1:0];
         rsp_flag   <= op_sel ^ sum[WIDTH];
         rsp_id     <= gnt_id;
         ptr_q      <= (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      end
   end

   assign rsp_valid = (state_q == FULL);
   assign busy      = rsp_valid || (|req_valid);

endmodule
